// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared state encoding and default widths for mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : two requester ports plus the single-port memory bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req0, req1;
  logic              wr0, wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_rd, mem_wr, mem_en;
  logic [DATA_W-1:0] mem_out;
  logic              busy;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_out,
    output ack0, ack1, rdata0, rdata1, mem_addr, mem_data,
           mem_rd, mem_wr, mem_en, busy
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_out,
    input  ack0, ack1, rdata0, rdata1, mem_addr, mem_data,
           mem_rd, mem_wr, mem_en, busy
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2 : combinational two-way round-robin pick
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  wire logic [1:0] req_i,
  input  wire logic       last_i,
  output logic            grant_o
);

  // A lone request wins outright; a tie goes to the port not served last.
  assign grant_o = (req_i == 2'b11) ? ~last_i : req_i[1];

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : two-port round-robin arbiter onto one synchronous memory port
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mem_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [1:0]        req_vec;
  logic              win;

  // The port being acknowledged still holds req this cycle; mask it out.
  always_comb begin
    req_vec = {bus.req1, bus.req0};
    if (state_q == RESP) begin
      req_vec[gnt_q] = 1'b0;
    end
  end

  rr_arb2 u_rr_arb2 (
    .req_i   (req_vec),
    .last_i  (last_q),
    .grant_o (win)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (|req_vec) begin
          state_d = ACCESS;
          last_d  = win;
          gnt_d   = win;
          wr_d    = win ? bus.wr1    : bus.wr0;
          addr_d  = win ? bus.addr1  : bus.addr0;
          wdata_d = win ? bus.wdata1 : bus.wdata0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == ACCESS && !wr_q) begin
      if (gnt_q) begin
        rdata1_q <= bus.mem_out;
      end else begin
        rdata0_q <= bus.mem_out;
      end
    end
  end

  // Strobes decode straight from state so an async reset kills them at once.
  always_comb begin
    bus.mem_en   = (state_q == ACCESS);
    bus.mem_wr   = (state_q == ACCESS) &&  wr_q;
    bus.mem_rd   = (state_q == ACCESS) && !wr_q;
    bus.mem_addr = addr_q;
    bus.mem_data = wdata_q;
    bus.ack0     = (state_q == RESP) && !gnt_q;
    bus.ack1     = (state_q == RESP) &&  gnt_q;
    bus.rdata0   = rdata0_q;
    bus.rdata1   = rdata1_q;
    bus.busy     = (state_q != IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] mem [0:65535];

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_out = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wr) mem[bus.mem_addr] <= bus.mem_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit r, input bit w,
                       input logic [15:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? bus.ack0 : bus.ack1;
  endfunction

  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? bus.rdata0 : bus.rdata1;
  endfunction

  // One isolated transaction on port p; exp_rd is checked for reads only.
  task automatic xact(input string tag, input int p, input bit w,
                      input logic [15:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd);
    drive(p, 1'b1, w, a, d);
    tick();
    chk({tag, ".en"},   32'(bus.mem_en), 32'd1);
    chk({tag, ".wr"},   32'(bus.mem_wr), 32'(w));
    chk({tag, ".rd"},   32'(bus.mem_rd), 32'(!w));
    chk({tag, ".addr"}, 32'(bus.mem_addr), 32'(a));
    chk({tag, ".ack_early"}, 32'(ack_of(p)), 32'd0);
    tick();
    chk({tag, ".ack"},   32'(ack_of(p)), 32'd1);
    chk({tag, ".other"}, 32'(ack_of(1 - p)), 32'd0);
    chk({tag, ".en_off"}, 32'(bus.mem_en), 32'd0);
    if (!w) chk({tag, ".rdata"}, rdata_of(p), exp_rd);
    drive(p, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
    chk({tag, ".ack_one"}, 32'(ack_of(p)), 32'd0);
  endtask

  initial begin
    int exp_port [4];
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);

    // Reset state
    #12;
    chk("rst.busy",  32'(bus.busy),   32'd0);
    chk("rst.en",    32'(bus.mem_en), 32'd0);
    chk("rst.wr",    32'(bus.mem_wr), 32'd0);
    chk("rst.ack0",  32'(bus.ack0),   32'd0);
    chk("rst.ack1",  32'(bus.ack1),   32'd0);
    chk("rst.addr",  32'(bus.mem_addr), 32'd0);
    chk("rst.data",  bus.mem_data,    32'd0);
    chk("rst.rd0",   bus.rdata0,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Simultaneous first requests: port 0 wins, port 1 follows 2 cycles later
    drive(0, 1'b1, 1'b1, 16'd15, 32'd123);
    drive(1, 1'b1, 1'b1, 16'd16, 32'd223);
    tick();
    chk("tie.busy",  32'(bus.busy),     32'd1);
    chk("tie.addr0", 32'(bus.mem_addr), 32'd15);
    chk("tie.data0", bus.mem_data,      32'd123);
    chk("tie.wr0",   32'(bus.mem_wr),   32'd1);
    tick();
    chk("tie.ack0",  32'(bus.ack0), 32'd1);
    chk("tie.ack1n", 32'(bus.ack1), 32'd0);
    chk("tie.en_resp", 32'(bus.mem_en), 32'd0);
    chk("tie.hold_addr", 32'(bus.mem_addr), 32'd15);
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    chk("tie.addr1", 32'(bus.mem_addr), 32'd16);
    chk("tie.ack0_drop", 32'(bus.ack0), 32'd0);
    tick();
    chk("tie.ack1",  32'(bus.ack1), 32'd1);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    chk("tie.idle",  32'(bus.busy), 32'd0);
    chk("tie.mem15", mem[15], 32'd123);
    chk("tie.mem16", mem[16], 32'd223);

    // Port 0 write/read 15; port 0 reads port 1's write at 16
    xact("p0w15", 0, 1'b1, 16'd15, 32'd123, 32'd0);
    xact("p0r15", 0, 1'b0, 16'd15, 32'd0,   32'd123);
    xact("p1w16", 1, 1'b1, 16'd16, 32'd223, 32'd0);
    xact("p0r16", 0, 1'b0, 16'd16, 32'd0,   32'd223);
    chk("rd1.untouched", bus.rdata1, 32'd0);

    // rdata1 holds across a port 1 write
    xact("p1r15", 1, 1'b0, 16'd15, 32'd0, 32'd123);
    xact("p1w17", 1, 1'b1, 16'd17, 32'd9, 32'd0);
    chk("rd1.hold", bus.rdata1, 32'd123);
    chk("rd0.hold", bus.rdata0, 32'd223);

    // Both ports hold reads: last grant was port 1 so order is 0,1,0,1
    exp_port = '{0, 1, 0, 1};
    drive(0, 1'b1, 1'b0, 16'd16, 32'h0);
    drive(1, 1'b1, 1'b0, 16'd17, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr%0d.addr", k), 32'(bus.mem_addr),
          (exp_port[k] == 0) ? 32'd16 : 32'd17);
      chk($sformatf("rr%0d.noack", k), 32'(bus.ack0 | bus.ack1), 32'd0);
      tick();
      chk($sformatf("rr%0d.ack", k), 32'(ack_of(exp_port[k])), 32'd1);
      chk($sformatf("rr%0d.oth", k), 32'(ack_of(1 - exp_port[k])), 32'd0);
      if (k == 3) begin
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
      end
    end
    chk("rr.rd0", bus.rdata0, 32'd223);
    chk("rr.rd1", bus.rdata1, 32'd9);
    tick();
    chk("rr.idle", 32'(bus.busy), 32'd0);

    // Address/data changes during ACCESS must not leak into the access
    xact("pre21", 0, 1'b1, 16'h0021, 32'h1111, 32'd0);
    drive(0, 1'b1, 1'b1, 16'h0020, 32'h0000A5A5);
    tick();
    drive(0, 1'b1, 1'b1, 16'h0021, 32'h0000FFFF);
    #1;
    chk("lat.addr", 32'(bus.mem_addr), 32'h20);
    chk("lat.data", bus.mem_data,      32'h0000A5A5);
    tick();
    chk("lat.ack", 32'(bus.ack0), 32'd1);
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    xact("lat.r20", 0, 1'b0, 16'h0020, 32'd0, 32'h0000A5A5);
    xact("lat.r21", 0, 1'b0, 16'h0021, 32'd0, 32'h00001111);

    // Reset during a port 1 write in ACCESS aborts it with no ack
    xact("pre7", 1, 1'b1, 16'd7, 32'h55555555, 32'd0);
    drive(1, 1'b1, 1'b1, 16'd7, 32'hDEADBEEF);
    tick();
    chk("abort.wr_on", 32'(bus.mem_wr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.wr_off", 32'(bus.mem_wr), 32'd0);
    chk("abort.en_off", 32'(bus.mem_en), 32'd0);
    chk("abort.busy",   32'(bus.busy),   32'd0);
    chk("abort.rd1",    bus.rdata1,      32'd0);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    chk("abort.ack1", 32'(bus.ack1), 32'd0);
    chk("abort.mem7", mem[7], 32'h55555555);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("abort.ack1_post", 32'(bus.ack1), 32'd0);
    xact("abort.r7", 0, 1'b0, 16'd7, 32'd0, 32'h55555555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
